fetch_line_responder: RTL and testbench

- Responder side of the prefetch-queue fetch interface. Drop-in replacement for the single-cycle instruction BRAM when instructions live behind a narrow 32-bit backing memory.
- Samples the queue's aligned fetch address and reads the line one word at a time through a request/response port. It assembles the words into one line and returns it with a one-cycle `readValid` pulse.
- A `redirect` aborts the fetch in flight. Any backing-memory response already owed is drained and discarded, and no stale line is delivered.

---
 rtl/fetch_line_responder.sv | 122 ++++++++++++
 tb/tb_fetch_line_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_responder.sv
// Fetch-line responder: fills one instruction line word by word from a 32-bit
// request/response memory and returns it with a single-cycle readValid pulse.
module fetch_line_responder #(
    parameter int LINE_WORDS    = 4,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDRESS_WIDTH-1:0]   readAddress,
    output logic [32*LINE_WORDS-1:0]   readData,
    output logic                       readValid,
    output logic                       memRequest,
    output logic [ADDRESS_WIDTH-1:0]   memAddress,
    input  logic                       memReady,
    input  logic                       memResponseValid,
    input  logic [31:0]                memResponseData
);
    localparam int INDEX_WIDTH  = $clog2(LINE_WORDS);
    localparam int OFFSET_WIDTH = $clog2(4 * LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DELIVER
    } stateType;

    stateType                  state;
    stateType                  stateNext;
    logic [ADDRESS_WIDTH-1:0]  base;
    logic [INDEX_WIDTH-1:0]    index;
    logic                      handshake;
    logic                      lastWord;
    logic                      sample;
    logic                      takeWord;
    logic                      unusedOffset;

    assign handshake    = memRequest & memReady;
    assign lastWord     = (index == INDEX_WIDTH'(LINE_WORDS - 1));
    assign unusedOffset = ^readAddress[OFFSET_WIDTH-1:0];

    // Word offsets stay inside the line, so OR-ing the offset equals adding it.
    assign memAddress = base | {{(ADDRESS_WIDTH - INDEX_WIDTH - 2){1'b0}}, index, 2'b00};

    always_comb begin
        stateNext = state;
        sample    = 1'b0;
        takeWord  = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect) begin
                    sample    = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    stateNext = redirect ? DRAIN : WAIT;
                end else if (redirect) begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (memResponseValid) begin
                    if (redirect) begin
                        stateNext = IDLE;
                    end else begin
                        takeWord  = 1'b1;
                        stateNext = lastWord ? DELIVER : ISSUE;
                    end
                end else if (redirect) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (memResponseValid) begin
                    stateNext = IDLE;
                end
            end
            DELIVER: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request and valid are registered from the next state to keep them glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            readValid  <= 1'b0;
            memRequest <= 1'b0;
        end else begin
            state      <= stateNext;
            readValid  <= (stateNext == DELIVER);
            memRequest <= (stateNext == ISSUE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base     <= '0;
            index    <= '0;
            readData <= '0;
        end else begin
            if (sample) begin
                base  <= {readAddress[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                index <= '0;
            end
            if (takeWord) begin
                for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                    if (index == INDEX_WIDTH'(k)) begin
                        readData[32*k +: 32] <= memResponseData;
                    end
                end
                if (!lastWord) begin
                    index <= index + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder: a backing-memory model that returns
// word == address, with per-address stall and response-delay knobs.
module tb_fetch_line_responder;
    localparam int LW = 4;
    localparam int AW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              redirect;
    logic [AW-1:0]     readAddress;
    logic [32*LW-1:0]  readData;
    logic              readValid;
    logic              memRequest;
    logic [AW-1:0]     memAddress;
    logic              memReady;
    logic              memResponseValid;
    logic [31:0]       memResponseData;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulsesBefore;

    logic          readyDefault = 1'b1;
    logic [AW-1:0] stallAddr    = '1;
    int            stallLeft    = 0;
    int            stallSeen    = 0;
    logic [AW-1:0] delayAddr    = '1;
    int            delayCycles  = 0;
    logic [AW-1:0] reqLog[$];
    logic          pending      = 1'b0;
    logic [AW-1:0] pendAddr     = '0;
    int            pendDelay    = 0;

    fetch_line_responder #(
        .LINE_WORDS    (LW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .redirect         (redirect),
        .readAddress      (readAddress),
        .readData         (readData),
        .readValid        (readValid),
        .memRequest       (memRequest),
        .memAddress       (memAddress),
        .memReady         (memReady),
        .memResponseValid (memResponseValid),
        .memResponseData  (memResponseData)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Memory model runs mid-cycle so it never races the DUT's rising edge.
    initial begin
        memReady         = 1'b0;
        memResponseValid = 1'b0;
        memResponseData  = '0;
        forever begin
            @(negedge clock);
            memResponseValid = 1'b0;
            if (readValid) pulses++;
            if (reset) begin
                pending  = 1'b0;
                memReady = readyDefault;
            end else begin
                if (pending) begin
                    if (pendDelay == 0) begin
                        memResponseValid = 1'b1;
                        memResponseData  = pendAddr;
                        pending          = 1'b0;
                        checkValue("respWhileRequest", memRequest, 0);
                    end else begin
                        pendDelay--;
                    end
                end
                memReady = readyDefault;
                if (memRequest && memAddress == stallAddr && stallLeft > 0) begin
                    memReady = 1'b0;
                    stallLeft--;
                    stallSeen++;
                end
                if (memRequest && memReady) begin
                    checkValue("oneOutstanding", pending, 0);
                    pending   = 1'b1;
                    pendAddr  = memAddress;
                    pendDelay = (memAddress == delayAddr) ? delayCycles : 0;
                    reqLog.push_back(memAddress);
                end
            end
        end
    end

    // Starts in IDLE with redirect high; latency counts cycles from the sampling cycle.
    task automatic fetchLine(input string tag, input logic [AW-1:0] addr, input int expLatency,
                             input logic [127:0] expData);
        int waited = 0;
        readAddress = addr;
        redirect    = 1'b0;
        do begin
            @(posedge clock); #1;
            waited++;
        end while (!readValid && waited < 40);
        checkValue({tag, "Valid"}, readValid, 1);
        checkValue({tag, "Latency"}, waited, expLatency);
        checkValue({tag, "Data"}, readData, expData);
        redirect = 1'b1;
        @(posedge clock); #1;
        checkValue({tag, "Pulse"}, readValid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b1;
        readAddress = '0;
        repeat (3) @(posedge clock);
        #1;
        checkValue("rstValid", readValid, 0);
        checkValue("rstData", readData, 0);
        checkValue("rstReq", memRequest, 0);
        checkValue("rstAddr", memAddress, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        fetchLine("basic", 'h28, 9, {32'h2C, 32'h28, 32'h24, 32'h20});
        checkValue("basicReqCount", reqLog.size(), 4);
        checkValue("basicReq0", reqLog[0], 'h20);
        checkValue("basicReq1", reqLog[1], 'h24);
        checkValue("basicReq2", reqLog[2], 'h28);
        checkValue("basicReq3", reqLog[3], 'h2C);
        reqLog.delete();

        stallAddr = 'h24;
        stallLeft = 3;
        stallSeen = 0;
        fetchLine("stall", 'h28, 12, {32'h2C, 32'h28, 32'h24, 32'h20});
        checkValue("stallCycles", stallSeen, 3);
        checkValue("stallReqCount", reqLog.size(), 4);
        checkValue("stallReq1", reqLog[1], 'h24);
        stallAddr = '1;
        reqLog.delete();

        // Redirect while 0x24 is outstanding; its response arrives two cycles late.
        delayAddr    = 'h24;
        delayCycles  = 2;
        pulsesBefore = pulses;
        readAddress  = 'h20;
        redirect     = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkValue("waitNoReq", memRequest, 0);
        redirect = 1'b1;
        @(posedge clock); #1;
        checkValue("drainNoReq", memRequest, 0);
        fetchLine("afterDrain", 'h40, 11, {32'h4C, 32'h48, 32'h44, 32'h40});
        checkValue("drainPulses", pulses - pulsesBefore, 1);
        checkValue("drainReqCount", reqLog.size(), 6);
        checkValue("drainReq2", reqLog[2], 'h40);
        delayAddr = '1;
        reqLog.delete();

        // Redirect in the same cycle as the final word's response.
        pulsesBefore = pulses;
        readAddress  = 'h20;
        redirect     = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        redirect = 1'b1;
        @(posedge clock); #1;
        checkValue("coincNoValid", readValid, 0);
        checkValue("coincNoReq", memRequest, 0);
        fetchLine("afterCoinc", 'h44, 9, {32'h4C, 32'h48, 32'h44, 32'h40});
        checkValue("coincPulses", pulses - pulsesBefore, 1);

        // Redirect in ISSUE without a handshake.
        readyDefault = 1'b0;
        reqLog.delete();
        readAddress  = 'h60;
        redirect     = 1'b0;
        @(posedge clock); #1;
        checkValue("issueReq", memRequest, 1);
        checkValue("issueAddr", memAddress, 'h60);
        redirect = 1'b1;
        @(posedge clock); #1;
        checkValue("issueDrop", memRequest, 0);
        readyDefault = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkValue("issueNoHandshake", reqLog.size(), 0);
        fetchLine("afterIssue", 'h8C, 9, {32'h8C, 32'h88, 32'h84, 32'h80});

        // Reset while waiting for the third word.
        readAddress = 'h20;
        redirect    = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checkValue("midAddr", memAddress, 'h28);
        reset    = 1'b1;
        redirect = 1'b1;
        @(posedge clock); #1;
        checkValue("midRstValid", readValid, 0);
        checkValue("midRstData", readData, 0);
        checkValue("midRstReq", memRequest, 0);
        checkValue("midRstAddr", memAddress, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        fetchLine("afterReset", 'h00, 9, {32'h0C, 32'h08, 32'h04, 32'h00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
